// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for the write-back stage: a head register drives the outputs
// and a skid register absorbs one extra entry, so in_ready never depends on out_ready.
module pipe_skid_reg #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_rf_waddr,
    input  logic              in_rf_wen,
    input  logic              in_wdata_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_rf_waddr,
    output logic              out_rf_wen,
    output logic              out_wdata_sel,
    output logic [1:0]        occupancy
);

    // Entry layout, MSB first: {data, waddr, wen, wdata_sel}
    localparam int EW = DATA_W + ADDR_W + 2;

    logic          headVld_q, headVld_d;
    logic          skidVld_q, skidVld_d;
    logic [EW-1:0] headEnt_q, headEnt_d;
    logic [EW-1:0] skidEnt_q, skidEnt_d;
    logic [EW-1:0] inEnt;
    logic          accept;
    logic          consume;
    logic          headFree;

    assign inEnt    = {in_data, in_rf_waddr, in_rf_wen, in_wdata_sel};
    assign in_ready = ~skidVld_q;
    assign accept   = in_valid & ~skidVld_q;
    assign consume  = headVld_q & out_ready;
    assign headFree = ~headVld_q | consume;

    // The skid entry is always older than the incoming one, so it refills the head first.
    // Only valid bits change on flush; payload fields keep their last value.
    always_comb begin
        headVld_d = headVld_q;
        skidVld_d = skidVld_q;
        headEnt_d = headEnt_q;
        skidEnt_d = skidEnt_q;
        if (flush) begin
            headVld_d = 1'b0;
            skidVld_d = 1'b0;
        end else begin
            if (headFree) begin
                if (skidVld_q) begin
                    headEnt_d = skidEnt_q;
                    headVld_d = 1'b1;
                    skidVld_d = 1'b0;
                end else if (accept) begin
                    headEnt_d = inEnt;
                    headVld_d = 1'b1;
                end else begin
                    headVld_d = 1'b0;
                end
            end
            if (accept && headVld_q && !consume) begin
                skidEnt_d = inEnt;
                skidVld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            headVld_q <= 1'b0;
            skidVld_q <= 1'b0;
            headEnt_q <= '0;
            skidEnt_q <= '0;
        end else begin
            headVld_q <= headVld_d;
            skidVld_q <= skidVld_d;
            headEnt_q <= headEnt_d;
            skidEnt_q <= skidEnt_d;
        end
    end

    // An empty head must never leave a stale write request on the register-file port.
    assign out_valid     = headVld_q;
    assign out_data      = headEnt_q[EW-1 -: DATA_W];
    assign out_rf_waddr  = headEnt_q[ADDR_W+1 -: ADDR_W];
    assign out_rf_wen    = headEnt_q[1] & headVld_q;
    assign out_wdata_sel = headEnt_q[0];
    assign occupancy     = {1'b0, headVld_q} + {1'b0, skidVld_q};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic,
// all compared every cycle against an ordered-queue reference model.
module tb_pipe_skid_reg;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  waddr;
        logic        wen;
        logic        sel;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_rf_wen, in_wdata_sel;
    logic [15:0] in_data;
    logic [3:0]  in_rf_waddr;
    logic        out_valid, out_ready, out_rf_wen, out_wdata_sel;
    logic [15:0] out_data;
    logic [3:0]  out_rf_waddr;
    logic [1:0]  occupancy;

    entry_t modelQ[$];
    entry_t lastHead;
    int     numChecks = 0;
    int     numFails  = 0;

    pipe_skid_reg #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rf_waddr(in_rf_waddr), .in_rf_wen(in_rf_wen), .in_wdata_sel(in_wdata_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rf_waddr(out_rf_waddr), .out_rf_wen(out_rf_wen), .out_wdata_sel(out_wdata_sel),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    // Model view: the block is an ordered queue of at most two entries; whatever sat at the
    // front last keeps showing on the data outputs once the queue drains.
    task automatic compareModel();
        int n;
        n = modelQ.size();
        checkOutput("out_valid", 32'(out_valid), 32'(n > 0));
        checkOutput("in_ready", 32'(in_ready), 32'(n < 2));
        checkOutput("occupancy", 32'(occupancy), 32'(n));
        checkOutput("out_data", 32'(out_data), 32'(lastHead.data));
        checkOutput("out_rf_waddr", 32'(out_rf_waddr), 32'(lastHead.waddr));
        checkOutput("out_wdata_sel", 32'(out_wdata_sel), 32'(lastHead.sel));
        checkOutput("out_rf_wen", 32'(out_rf_wen), 32'((n > 0) && lastHead.wen));
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic iv, input logic [15:0] d,
                                 input logic [3:0] a, input logic w, input logic s, input logic oR);
        entry_t e;
        bit     doPop, doPush;
        rst = r; flush = f; in_valid = iv; in_data = d;
        in_rf_waddr = a; in_rf_wen = w; in_wdata_sel = s; out_ready = oR;
        e = '{data: d, waddr: a, wen: w, sel: s};
        doPop  = (modelQ.size() > 0) && oR;
        doPush = iv && (modelQ.size() < 2);
        @(posedge clk);
        if (r) begin
            modelQ.delete();
            lastHead = '0;
        end else if (f) begin
            modelQ.delete();
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back(e);
        end
        if (modelQ.size() > 0) lastHead = modelQ[0];
        #1;
        compareModel();
    endtask

    initial begin
        lastHead = '0;
        applyStimulus(1, 0, 1, 16'hFFFF, 4'hF, 1, 1, 1);
        checkOutput("reset_out_data", 32'(out_data), 32'h0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'h1);

        // Pass-through
        applyStimulus(0, 0, 1, 16'h1234, 4'd3, 1, 0, 1);
        checkOutput("pass_data", 32'(out_data), 32'h1234);
        checkOutput("pass_wen", 32'(out_rf_wen), 32'h1);
        applyStimulus(0, 0, 0, 16'h0, 4'd0, 0, 0, 1);

        // Back-pressure then drain in order
        applyStimulus(0, 0, 1, 16'hAAAA, 4'd1, 1, 1, 0);
        applyStimulus(0, 0, 1, 16'hBBBB, 4'd2, 1, 0, 0);
        checkOutput("bp_occupancy", 32'(occupancy), 32'd2);
        applyStimulus(0, 0, 1, 16'hCCCC, 4'd4, 1, 0, 0);
        checkOutput("bp_full_head", 32'(out_data), 32'hAAAA);
        applyStimulus(0, 0, 0, 16'h0, 4'd0, 0, 0, 1);
        checkOutput("bp_second", 32'(out_data), 32'hBBBB);
        applyStimulus(0, 0, 0, 16'h0, 4'd0, 0, 0, 1);

        // Streaming 0..7
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 16'(i), 4'(i), 1, 1, 1);
            checkOutput("stream_data", 32'(out_data), 32'(i));
        end
        applyStimulus(0, 0, 0, 16'h0, 4'd0, 0, 0, 1);

        // Flush while full with a concurrent incoming entry
        applyStimulus(0, 0, 1, 16'h1111, 4'd5, 1, 0, 0);
        applyStimulus(0, 0, 1, 16'h2222, 4'd6, 1, 0, 0);
        applyStimulus(0, 1, 1, 16'h3333, 4'd7, 1, 0, 1);
        checkOutput("flush_occupancy", 32'(occupancy), 32'd0);
        applyStimulus(0, 0, 0, 16'h0, 4'd0, 0, 0, 1);

        // Reset while full
        applyStimulus(0, 0, 1, 16'h4444, 4'd8, 1, 1, 0);
        applyStimulus(0, 0, 1, 16'h5555, 4'd9, 1, 0, 0);
        applyStimulus(1, 0, 1, 16'h6666, 4'hA, 1, 1, 0);
        checkOutput("rst_mid_data", 32'(out_data), 32'h0);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(($urandom_range(0, 499) == 0),
                          ($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 3) != 0),
                          16'($urandom()), 4'($urandom()), 1'($urandom()), 1'($urandom()),
                          1'($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the result data field.
REQ-002 SHALL have parameter ADDR_W, default 4, width of the register-file write address.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all held entries (pipeline squash).
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_ready  output  1  block accepts an entry this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  result data.
REQ-009 SHALL have port in_rf_waddr  input  ADDR_W  destination register.
REQ-010 SHALL have port in_rf_wen  input  1  register-file write request.
REQ-011 SHALL have port in_wdata_sel  input  1  write-back data source select.
REQ-012 SHALL have port out_valid  output  1  head entry present.
REQ-013 SHALL have port out_ready  input  1  downstream consumes head this cycle.
REQ-014 SHALL have ports out_data (DATA_W), out_rf_waddr (ADDR_W), out_rf_wen (1), out_wdata_sel (1)  outputs  head entry fields.
REQ-015 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 SHALL hold up to two entries: head register (drives out_*) and skid register; each entry = {data, waddr, wen, wdata_sel} plus valid bit.
REQ-017 SHALL define accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-018 SHALL drive in_ready = ~skid_valid, from a register only (no combinational path from out_ready).
REQ-019 SHALL drive out_valid = head_valid; all out_* fields SHALL come directly from head registers.
REQ-020 SHALL preserve FIFO order: skid entry is always older than any newly accepted entry.
REQ-021 Head update on no flush: if head empty or consume, head loads skid entry when skid valid, else incoming entry when accept, else head_valid clears.
REQ-022 Skid update on no flush: skid loads incoming entry when accept, head valid, and no consume; skid clears when it moves into head; otherwise holds.
REQ-023 SHALL give 1-cycle latency: entry accepted at edge N appears on out_* after edge N when block empty.
REQ-024 SHALL sustain one accept and one consume per cycle with occupancy 1 (full throughput, no bubbles).
REQ-025 Full (occupancy 2): in_ready=0; in_valid ignored; entries held until consume.
REQ-026 Empty: out_valid=0; out_ready ignored.
REQ-027 SHALL force out_rf_wen = head_wen & head_valid, so an invalid head never requests a register-file write.
REQ-028 Data fields of an entry SHALL retain their last value when invalid (only valid bits cleared).
REQ-029 flush SHALL clear head_valid and skid_valid at the next edge; concurrent accept and consume SHALL be ignored (flush priority over both).
REQ-030 occupancy SHALL equal head_valid + skid_valid.

Reset
REQ-031 rst SHALL, at the next rising edge, clear head_valid, skid_valid and all data fields to 0; rst has priority over flush and handshakes.
REQ-032 After reset: out_valid=0, out_rf_wen=0, in_ready=1, occupancy=0, out_data=0, out_rf_waddr=0, out_wdata_sel=0.
REQ-033 rst mid-operation SHALL drop all held entries with no residual write request.

Verification
REQ-034 Pass-through: out_ready=1, in_valid=1 with data 0x1234, waddr 3, wen 1 -> next cycle out_valid=1, out_data=0x1234, out_rf_waddr=3, out_rf_wen=1, occupancy=1.
REQ-035 Back-pressure: out_ready=0, send 0xAAAA then 0xBBBB -> occupancy 2, in_ready=0; raise out_ready -> outputs 0xAAAA then 0xBBBB on consecutive cycles, in_ready returns 1.
REQ-036 Streaming: 8 back-to-back entries 0..7 with out_ready=1 -> 8 consecutive valid outputs in order, in_ready constantly 1.
REQ-037 Flush: occupancy 2 plus in_valid=1 and flush=1 -> next cycle out_valid=0, out_rf_wen=0, occupancy=0, in_ready=1; flushed entries never appear.
REQ-038 Reset mid-stream: occupancy 2, rst=1 -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1.
REQ-039 Random in_valid/out_ready/flush for 10k cycles against a reference queue model -> order, data and occupancy match every cycle; no output while out_valid=0.
